sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised per-pixel sprite compositor for the VGA snake pipeline. Each cycle it takes the raster coordinate and a background pixel, and hit-tests up to NUM_SPRITES frame-latched sprites. It fetches the winning sprite's texel from a shared sprite-atlas ROM and emits the composited 12-bit pixel after a fixed latency. It also reports a per-frame head-overlap flag for game logic, and applies PLAY/WIN/LOSE screen modes.

## Interface
- NUM_SPRITES, 24: sprite slots; slot 0 is the snake head and has the highest priority.
- COORD_W, 11: raster/sprite coordinate width.
- SPR_W, 32 / SPR_H, 32: sprite size in pixels; each must be a power of two.
- NUM_IMGS, 8: atlas images; IMG_W = clog2(NUM_IMGS).
- ROM_LAT, 1: atlas ROM read latency in cycles (≥1).
- KEY_COLOR, 12'h000: transparent texel value.
- ADDR_W: derived, clog2(NUM_IMGS*SPR_W*SPR_H).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank; latches sprite attributes.
- sprite_x, sprite_y  in  NUM_SPRITES*COORD_W  top-left corner per slot; slot i is at [i*COORD_W +: COORD_W].
- sprite_en  in  NUM_SPRITES  slot enable.
- sprite_img  in  NUM_SPRITES*IMG_W  atlas image index per slot.
- mode  in  2  0 = PLAY, 1 = WIN, 2 = LOSE, 3 = PLAY.
- pix_valid  in  1  curr_x/curr_y/bg_pixel valid this cycle.
- curr_x, curr_y  in  COORD_W  raster coordinate.
- bg_pixel  in  12  background (grass) pixel for this coordinate.
- rom_addr  out  ADDR_W  atlas ROM address.
- rom_pixel  in  12  atlas data, valid ROM_LAT cycles after rom_addr.
- pix_out  out  12  composited RGB444 pixel {r,g,b}.
- pix_valid_out  out  1  pix_out valid.
- collide  out  1  head overlapped an enabled body slot during the previous frame.

## Operation
- **Shadow registers.** On frame_start, sprite_x/y/en/img are copied into shadow registers. Only the shadow copies are used for hit tests. A pixel presented in the same cycle as frame_start uses the old shadow values.
- **Hit test.** Slot i hits when en_i && x_i ≤ curr_x < x_i+SPR_W && y_i ≤ curr_y < y_i+SPR_H. Compare in COORD_W+1 bits so a sprite near 2^COORD_W does not wrap to column 0.
- **Priority.** Among hitting slots, the lowest index wins.
- **ROM address.** Address = img*SPR_W*SPR_H + dy*SPR_W + dx, where dx = curr_x−x and dy = curr_y−y. Build it by concatenation (power-of-two sizes); no multipliers.
- **No hit.** When no slot hits, rom_addr holds its previous value and the pixel takes the background path.
- **Compose, PLAY mode.** Output the texel if a sprite hit and texel ≠ KEY_COLOR; otherwise output the delayed bg_pixel. Transparency falls through to the background only, not to lower-priority sprites.
- **Compose, WIN mode.** Sprites are shown. Non-sprite and transparent pixels become 12'h0F0.
- **Compose, LOSE mode.** All pixels become 12'hF00 and sprites are suppressed.
- **Mode sampling.** mode is sampled together with the pixel at stage 0 and pipelined alongside it.
- **Collision.** The sticky accumulator col_acc sets when, for a valid pixel, slot 0 and any slot j≥1 with en_j both hit (bounding-box overlap). On frame_start, collide ← col_acc and col_acc is cleared; an overlap pixel in that same cycle counts toward the new frame.
- **Idle pixels.** When pix_valid=0, the pixel advances through the pipeline as a bubble: pix_valid_out=0, and pix_out holds its last value.

## Timing
- **Pipeline stages.** Stage 0 registers the hit/winner/address, so rom_addr is registered. ROM_LAT delay stages follow, carrying hit, mode, bg_pixel and valid. A final output register follows.
- **Latency.** pix_valid → pix_valid_out is exactly ROM_LAT+2 cycles. Throughput is one pixel per cycle with no stall.
- **Collide.** collide updates 1 cycle after frame_start.
- **Reset.** On reset, shadow_en=0, all shadow coordinates=0, rom_addr=0, pix_out=12'h000, pix_valid_out=0, collide=0, col_acc=0, and the delay-line valid bits are cleared. Reset asserted mid-frame discards all in-flight pixels.

## Structure
- **Shared package.** sprite_pkg holds the RGB444 typedef, the mode enum (MODE_PLAY/WIN/LOSE), the COLOR_WIN/COLOR_LOSE constants and the clog2-derived ADDR_W helper.
- **Sub-module.** sprite_hit_prio holds the combinational parallel compare plus lowest-index priority encoder, outputting hit, idx, dx and dy. The ROM itself stays external.

## Test plan
- Reset, then PLAY with slot 3 at (100,50), img 2, enabled, and curr=(105,52). Expect rom_addr=2*1024+2*32+5=2117 one cycle later, and pix_out = the rom_pixel value 3 cycles after input (ROM_LAT=1).
- Slots 0 and 5 both covering (200,200); slot 0 texel 12'h000, bg_pixel=12'h3A3. Expect pix_out=12'h3A3 (slot 5 not shown) and collide=1 after the next frame_start.
- Change sprite_x of slot 1 mid-frame without frame_start. Expect the rendered position unchanged until frame_start is pulsed, then moved.
- Slot 2 at x=2040 and curr_x=3. Expect no hit (no wrap), pix_out=bg_pixel.
- mode=LOSE with a sprite hit. Expect 12'hF00. mode=WIN with no hit. Expect 12'h0F0.
- Continuous pix_valid with a two-cycle bubble, then rst asserted mid-stream. Expect the bubble to reappear at output after ROM_LAT+2 cycles, and all outputs 0 immediately on reset.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor pipeline.
package sprite_pkg;

    typedef logic [11:0] rgb444_t;

    typedef enum logic [1:0] {
        MODE_PLAY = 2'd0,
        MODE_WIN  = 2'd1,
        MODE_LOSE = 2'd2
    } mode_e;

    localparam rgb444_t COLOR_WIN  = 12'h0F0;
    localparam rgb444_t COLOR_LOSE = 12'hF00;

    // Atlas address width for a set of power-of-two sized images.
    function automatic int calc_addr_w(input int num_imgs, input int spr_w, input int spr_h);
        return $clog2(num_imgs * spr_w * spr_h);
    endfunction

    // Raw mode code 3 is treated as PLAY, as is any unknown code.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'd1:    m = MODE_WIN;
            2'd2:    m = MODE_LOSE;
            default: m = MODE_PLAY;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sprite_hit_prio.sv
// Parallel bounding-box hit test over all sprite slots plus a
// lowest-index-wins priority encoder. Purely combinational.
module sprite_hit_prio
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 24,
    parameter int COORD_W     = 11,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    localparam int IDX_W      = $clog2(NUM_SPRITES),
    localparam int DX_W       = $clog2(SPR_W),
    localparam int DY_W       = $clog2(SPR_H)
)(
    input  logic [COORD_W-1:0]             curr_x,
    input  logic [COORD_W-1:0]             curr_y,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
    input  logic [NUM_SPRITES-1:0]         spr_en,
    output logic [NUM_SPRITES-1:0]         hit_vec,
    output logic                           hit,
    output logic [IDX_W-1:0]               idx,
    output logic [DX_W-1:0]                dx,
    output logic [DY_W-1:0]                dy
);

    // One extra bit keeps x+SPR_W from wrapping back to column 0.
    localparam logic [COORD_W:0] SPR_W_E = (COORD_W+1)'(SPR_W);
    localparam logic [COORD_W:0] SPR_H_E = (COORD_W+1)'(SPR_H);

    logic [COORD_W:0] cx_s;
    logic [COORD_W:0] cy_s;
    logic [DX_W-1:0]  dx_slot_s [NUM_SPRITES];
    logic [DY_W-1:0]  dy_slot_s [NUM_SPRITES];

    assign cx_s = {1'b0, curr_x};
    assign cy_s = {1'b0, curr_y};

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
        logic [COORD_W:0] sx_s;
        logic [COORD_W:0] sy_s;
        logic [COORD_W:0] dxf_s;
        logic [COORD_W:0] dyf_s;

        assign sx_s  = {1'b0, spr_x[i*COORD_W +: COORD_W]};
        assign sy_s  = {1'b0, spr_y[i*COORD_W +: COORD_W]};
        assign dxf_s = cx_s - sx_s;
        assign dyf_s = cy_s - sy_s;
        // curr >= origin and offset inside the box is the same as origin <= curr < origin+size.
        assign hit_vec[i] = spr_en[i] && (cx_s >= sx_s) && (dxf_s < SPR_W_E)
                                      && (cy_s >= sy_s) && (dyf_s < SPR_H_E);
        assign dx_slot_s[i] = dxf_s[DX_W-1:0];
        assign dy_slot_s[i] = dyf_s[DY_W-1:0];
    end

    // Scan from the highest slot down so the lowest hitting index is the last one kept.
    always_comb begin
        hit = 1'b0;
        idx = {IDX_W{1'b0}};
        dx  = {DX_W{1'b0}};
        dy  = {DY_W{1'b0}};
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            hit = hit | hit_vec[i];
            idx = hit_vec[i] ? IDX_W'(i)    : idx;
            dx  = hit_vec[i] ? dx_slot_s[i] : dx;
            dy  = hit_vec[i] ? dy_slot_s[i] : dy;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel sprite compositor: frame-latched sprite table, hit test,
// atlas ROM addressing, ROM-latency-matched delay line, screen-mode
// compose and per-frame head-overlap flag.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int          NUM_SPRITES = 24,
    parameter int          COORD_W     = 11,
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter int          NUM_IMGS    = 8,
    parameter int          ROM_LAT     = 1,
    parameter logic [11:0] KEY_COLOR   = 12'h000,
    localparam int         IMG_W       = $clog2(NUM_IMGS),
    localparam int         ADDR_W      = calc_addr_w(NUM_IMGS, SPR_W, SPR_H)
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    input  logic [NUM_SPRITES*IMG_W-1:0]   sprite_img,
    input  logic [1:0]                     mode,
    input  logic                           pix_valid,
    input  logic [COORD_W-1:0]             curr_x,
    input  logic [COORD_W-1:0]             curr_y,
    input  logic [11:0]                    bg_pixel,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic [11:0]                    rom_pixel,
    output logic [11:0]                    pix_out,
    output logic                           pix_valid_out,
    output logic                           collide
);

    localparam int IDX_W = $clog2(NUM_SPRITES);
    localparam int DX_W  = $clog2(SPR_W);
    localparam int DY_W  = $clog2(SPR_H);

    // Frame-latched sprite table
    logic [NUM_SPRITES*COORD_W-1:0] shadow_x_r;
    logic [NUM_SPRITES*COORD_W-1:0] shadow_y_r;
    logic [NUM_SPRITES-1:0]         shadow_en_r;
    logic [NUM_SPRITES*IMG_W-1:0]   shadow_img_r;

    // Hit test results
    logic [NUM_SPRITES-1:0] hit_vec_s;
    logic                   hit_s;
    logic [IDX_W-1:0]       hit_idx_s;
    logic [DX_W-1:0]        hit_dx_s;
    logic [DY_W-1:0]        hit_dy_s;
    logic [IMG_W-1:0]       win_img_s;
    logic                   overlap_s;

    // Stage 0 plus ROM_LAT delay stages
    logic                   rom_addr_r;
    logic [ADDR_W-1:0]      addr_r;
    logic                   p_valid_r [0:ROM_LAT];
    logic                   p_hit_r   [0:ROM_LAT];
    mode_e                  p_mode_r  [0:ROM_LAT];
    rgb444_t                p_bg_r    [0:ROM_LAT];

    // Output stage
    logic                   texel_vis_s;
    rgb444_t                comp_s;
    rgb444_t                pix_out_r;
    logic                   pix_valid_out_r;
    logic                   col_acc_r;
    logic                   collide_r;

    assign rom_addr_r = 1'b0;

    sprite_hit_prio #(
        .NUM_SPRITES (NUM_SPRITES),
        .COORD_W     (COORD_W),
        .SPR_W       (SPR_W),
        .SPR_H       (SPR_H)
    ) u_hit_prio (
        .curr_x  (curr_x),
        .curr_y  (curr_y),
        .spr_x   (shadow_x_r),
        .spr_y   (shadow_y_r),
        .spr_en  (shadow_en_r),
        .hit_vec (hit_vec_s),
        .hit     (hit_s),
        .idx     (hit_idx_s),
        .dx      (hit_dx_s),
        .dy      (hit_dy_s)
    );

    // Latch the sprite table at vertical blank so a frame renders from one consistent snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_x_r   <= {(NUM_SPRITES*COORD_W){1'b0}};
            shadow_y_r   <= {(NUM_SPRITES*COORD_W){1'b0}};
            shadow_en_r  <= {NUM_SPRITES{1'b0}};
            shadow_img_r <= {(NUM_SPRITES*IMG_W){1'b0}};
        end else if (frame_start) begin
            shadow_x_r   <= sprite_x;
            shadow_y_r   <= sprite_y;
            shadow_en_r  <= sprite_en;
            shadow_img_r <= sprite_img;
        end
    end

    // Select the image index of the winning slot.
    always_comb begin
        win_img_s = {IMG_W{1'b0}};
        for (int i = 0; i < NUM_SPRITES; i++) begin
            win_img_s = (hit_idx_s == IDX_W'(i)) ? shadow_img_r[i*IMG_W +: IMG_W] : win_img_s;
        end
    end

    // Head overlaps an enabled body slot on a real pixel.
    assign overlap_s = pix_valid && hit_vec_s[0] && (|hit_vec_s[NUM_SPRITES-1:1]);

    // Sticky per-frame overlap; the frame_start cycle's overlap belongs to the new frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_acc_r <= 1'b0;
            collide_r <= 1'b0;
        end else if (frame_start) begin
            collide_r <= col_acc_r;
            col_acc_r <= overlap_s;
        end else begin
            col_acc_r <= col_acc_r | overlap_s;
        end
    end

    // Stage 0 registers the atlas address; delay stages carry pixel context across the ROM latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r <= {ADDR_W{1'b0}};
            for (int k = 0; k <= ROM_LAT; k++) begin
                p_valid_r[k] <= 1'b0;
                p_hit_r[k]   <= 1'b0;
                p_mode_r[k]  <= MODE_PLAY;
                p_bg_r[k]    <= 12'h000;
            end
        end else begin
            if (pix_valid && hit_s) begin
                addr_r <= {win_img_s, hit_dy_s, hit_dx_s};
            end
            p_valid_r[0] <= pix_valid;
            p_hit_r[0]   <= hit_s;
            p_mode_r[0]  <= decode_mode(mode);
            p_bg_r[0]    <= bg_pixel;
            for (int k = 1; k <= ROM_LAT; k++) begin
                p_valid_r[k] <= p_valid_r[k-1];
                p_hit_r[k]   <= p_hit_r[k-1];
                p_mode_r[k]  <= p_mode_r[k-1];
                p_bg_r[k]    <= p_bg_r[k-1];
            end
        end
    end

    // Merge texel, background and screen mode; transparent texels fall through to background only.
    always_comb begin
        texel_vis_s = p_hit_r[ROM_LAT] && (rom_pixel != KEY_COLOR);
        comp_s      = p_bg_r[ROM_LAT];
        case (p_mode_r[ROM_LAT])
            MODE_LOSE: comp_s = COLOR_LOSE;
            MODE_WIN:  comp_s = texel_vis_s ? rom_pixel : COLOR_WIN;
            default:   comp_s = texel_vis_s ? rom_pixel : p_bg_r[ROM_LAT];
        endcase
    end

    // Output register; bubbles leave pix_out at its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_out_r       <= 12'h000;
            pix_valid_out_r <= 1'b0;
        end else begin
            pix_valid_out_r <= p_valid_r[ROM_LAT];
            if (p_valid_r[ROM_LAT]) begin
                pix_out_r <= comp_s;
            end
        end
    end

    assign rom_addr      = addr_r | {{(ADDR_W-1){1'b0}}, rom_addr_r};
    assign pix_out       = pix_out_r;
    assign pix_valid_out = pix_valid_out_r;
    assign collide       = collide_r;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor (default parameters, ROM_LAT=1).
module tb_sprite_compositor;

    localparam int NS = 24;
    localparam int CW = 11;
    localparam int IW = 3;
    localparam int AW = 13;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            frame_start = 1'b0;
    logic [NS*CW-1:0] sprite_x = '0;
    logic [NS*CW-1:0] sprite_y = '0;
    logic [NS-1:0]   sprite_en = '0;
    logic [NS*IW-1:0] sprite_img = '0;
    logic [1:0]      mode = 2'd0;
    logic            pix_valid = 1'b0;
    logic [CW-1:0]   curr_x = '0;
    logic [CW-1:0]   curr_y = '0;
    logic [11:0]     bg_pixel = 12'h000;
    logic [AW-1:0]   rom_addr;
    logic [11:0]     rom_pixel = 12'h000;
    logic [11:0]     pix_out;
    logic            pix_valid_out;
    logic            collide;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sprite_compositor dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .sprite_en     (sprite_en),
        .sprite_img    (sprite_img),
        .mode          (mode),
        .pix_valid     (pix_valid),
        .curr_x        (curr_x),
        .curr_y        (curr_y),
        .bg_pixel      (bg_pixel),
        .rom_addr      (rom_addr),
        .rom_pixel     (rom_pixel),
        .pix_out       (pix_out),
        .pix_valid_out (pix_valid_out),
        .collide       (collide)
    );

    // External atlas ROM, one cycle latency: image 1 is fully transparent,
    // everything else returns the low address bits with the top nibble inverted.
    function automatic logic [11:0] rom_model(input logic [AW-1:0] a);
        if (a[12:10] == 3'd1) return 12'h000;
        return a[11:0] ^ 12'hF00;
    endfunction

    always @(posedge clk) rom_pixel <= rom_model(rom_addr);

    task automatic set_slot(input int i, input int x, input int y, input logic en, input int img);
        sprite_x[i*CW +: CW]   = CW'(x);
        sprite_y[i*CW +: CW]   = CW'(y);
        sprite_en[i]           = en;
        sprite_img[i*IW +: IW] = IW'(img);
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Present one pixel, capture rom_addr one cycle later, pix_valid_out two
    // cycles later (must still be 0) and the output three cycles later.
    task automatic run_pix(input int x, input int y, input logic [11:0] bg, input logic [1:0] md,
                           input logic fs, output logic [AW-1:0] addr_o, output logic [11:0] pix_o,
                           output logic vld_o, output logic early_o);
        @(negedge clk);
        curr_x = CW'(x); curr_y = CW'(y); bg_pixel = bg; mode = md;
        pix_valid = 1'b1; frame_start = fs;
        @(negedge clk);
        pix_valid = 1'b0; frame_start = 1'b0;
        addr_o = rom_addr;
        @(negedge clk);
        early_o = pix_valid_out;
        @(negedge clk);
        pix_o = pix_out;
        vld_o = pix_valid_out;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
        checks++; if (pix_out !== 12'h000) begin errors++; $display("FAIL reset_pix: got %h expected 000", pix_out); end
        checks++; if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pix_valid_out); end
        checks++; if (collide !== 1'b0) begin errors++; $display("FAIL reset_collide: got %b expected 0", collide); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [AW-1:0] a; logic [11:0] p; logic v, e;
        set_slot(3, 100, 50, 1'b1, 2);
        pulse_frame();
        run_pix(105, 52, 12'h123, 2'd0, 1'b0, a, p, v, e);
        checks++; if (a !== 13'd2117) begin errors++; $display("FAIL basic_addr: got %0d expected 2117", a); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_latency_early: got %b expected 0", e); end
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", v); end
        checks++; if (p !== 12'h745) begin errors++; $display("FAIL basic_pix: got %h expected 745", p); end
        // bottom-right corner of the sprite
        run_pix(131, 81, 12'h123, 2'd0, 1'b0, a, p, v, e);
        checks++; if (a !== 13'd3071) begin errors++; $display("FAIL corner_addr: got %0d expected 3071", a); end
        checks++; if (p !== 12'h4FF) begin errors++; $display("FAIL corner_pix: got %h expected 4ff", p); end
        // one past the right edge: background, address held
        run_pix(132, 50, 12'h456, 2'd0, 1'b0, a, p, v, e);
        checks++; if (a !== 13'd3071) begin errors++; $display("FAIL edge_addr_hold: got %0d expected 3071", a); end
        checks++; if (p !== 12'h456) begin errors++; $display("FAIL edge_pix: got %h expected 456", p); end
    endtask

    task automatic test_priority();
        logic [AW-1:0] a; logic [11:0] p; logic v, e;
        set_slot(0, 190, 190, 1'b1, 1);
        set_slot(5, 195, 195, 1'b1, 3);
        pulse_frame();
        run_pix(200, 200, 12'h3A3, 2'd0, 1'b0, a, p, v, e);
        checks++; if (a !== 13'd1354) begin errors++; $display("FAIL prio_addr: got %0d expected 1354", a); end
        checks++; if (p !== 12'h3A3) begin errors++; $display("FAIL prio_pix: got %h expected 3a3", p); end
        checks++; if (collide !== 1'b0) begin errors++; $display("FAIL collide_before: got %b expected 0", collide); end
        pulse_frame();
        checks++; if (collide !== 1'b1) begin errors++; $display("FAIL collide_set: got %b expected 1", collide); end
        pulse_frame();
        checks++; if (collide !== 1'b0) begin errors++; $display("FAIL collide_clear: got %b expected 0", collide); end
    endtask

    task automatic test_shadow();
        logic [AW-1:0] a; logic [11:0] p; logic v, e;
        set_slot(1, 300, 300, 1'b1, 2);
        pulse_frame();
        run_pix(300, 300, 12'h222, 2'd0, 1'b0, a, p, v, e);
        checks++; if (p !== 12'h700) begin errors++; $display("FAIL shadow_initial: got %h expected 700", p); end
        set_slot(1, 400, 300, 1'b1, 2);
        run_pix(400, 300, 12'h111, 2'd0, 1'b0, a, p, v, e);
        checks++; if (p !== 12'h111) begin errors++; $display("FAIL shadow_not_moved: got %h expected 111", p); end
        // pixel in the frame_start cycle still sees the old position
        run_pix(300, 300, 12'h222, 2'd0, 1'b1, a, p, v, e);
        checks++; if (p !== 12'h700) begin errors++; $display("FAIL shadow_same_cycle: got %h expected 700", p); end
        run_pix(300, 300, 12'h222, 2'd0, 1'b0, a, p, v, e);
        checks++; if (p !== 12'h222) begin errors++; $display("FAIL shadow_old_gone: got %h expected 222", p); end
        run_pix(400, 300, 12'h111, 2'd0, 1'b0, a, p, v, e);
        checks++; if (p !== 12'h700) begin errors++; $display("FAIL shadow_moved: got %h expected 700", p); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a; logic [11:0] p; logic v, e;
        set_slot(2, 2040, 0, 1'b1, 4);
        pulse_frame();
        run_pix(3, 0, 12'h456, 2'd0, 1'b0, a, p, v, e);
        checks++; if (p !== 12'h456) begin errors++; $display("FAIL wrap_nohit: got %h expected 456", p); end
        run_pix(2047, 0, 12'h456, 2'd0, 1'b0, a, p, v, e);
        checks++; if (a !== 13'd4103) begin errors++; $display("FAIL wrap_edge_addr: got %0d expected 4103", a); end
        checks++; if (p !== 12'hF07) begin errors++; $display("FAIL wrap_edge_pix: got %h expected f07", p); end
    endtask

    task automatic test_modes();
        logic [AW-1:0] a; logic [11:0] p; logic v, e;
        run_pix(105, 52, 12'h123, 2'd2, 1'b0, a, p, v, e);
        checks++; if (p !== 12'hF00) begin errors++; $display("FAIL lose_hit: got %h expected f00", p); end
        run_pix(600, 600, 12'h123, 2'd1, 1'b0, a, p, v, e);
        checks++; if (p !== 12'h0F0) begin errors++; $display("FAIL win_nohit: got %h expected 0f0", p); end
        run_pix(105, 52, 12'h123, 2'd1, 1'b0, a, p, v, e);
        checks++; if (p !== 12'h745) begin errors++; $display("FAIL win_hit: got %h expected 745", p); end
        run_pix(200, 200, 12'h123, 2'd1, 1'b0, a, p, v, e);
        checks++; if (p !== 12'h0F0) begin errors++; $display("FAIL win_transparent: got %h expected 0f0", p); end
        run_pix(600, 600, 12'h5C5, 2'd3, 1'b0, a, p, v, e);
        checks++; if (p !== 12'h5C5) begin errors++; $display("FAIL mode3_play: got %h expected 5c5", p); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  pat;
        logic [11:0] exp_pix;
        pat = 8'b1111_0011;
        exp_pix = 12'h000;
        mode = 2'd0;
        for (int t = 0; t < 11; t++) begin
            @(negedge clk);
            if (t >= 3) begin
                checks++;
                if (pix_valid_out !== pat[t-3]) begin
                    errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", t-3, pix_valid_out, pat[t-3]);
                end
                if (pat[t-3]) exp_pix = 12'h745 + 12'(t-3);
                checks++;
                if (pix_out !== exp_pix) begin
                    errors++; $display("FAIL b2b_pix[%0d]: got %h expected %h", t-3, pix_out, exp_pix);
                end
            end
            if (t < 8) begin
                curr_x = CW'(105 + t); curr_y = CW'(52); bg_pixel = 12'h123; pix_valid = pat[t];
            end else begin
                pix_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [AW-1:0] a; logic [11:0] p; logic v, e;
        run_pix(200, 200, 12'h3A3, 2'd0, 1'b0, a, p, v, e);
        pulse_frame();
        checks++; if (collide !== 1'b1) begin errors++; $display("FAIL pre_reset_collide: got %b expected 1", collide); end
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            curr_x = CW'(105); curr_y = CW'(52); mode = 2'd0; pix_valid = 1'b1;
        end
        @(negedge clk);
        checks++; if (pix_valid_out !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", pix_valid_out); end
        rst = 1'b0;
        #1;
        checks++; if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", pix_valid_out); end
        checks++; if (pix_out !== 12'h000) begin errors++; $display("FAIL mid_reset_pix: got %h expected 000", pix_out); end
        checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL mid_reset_addr: got %0d expected 0", rom_addr); end
        checks++; if (collide !== 1'b0) begin errors++; $display("FAIL mid_reset_collide: got %b expected 0", collide); end
        @(negedge clk);
        rst = 1'b1;
        pix_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            checks++;
            if (pix_valid_out !== 1'b0) begin
                errors++; $display("FAIL post_reset_flush[%0d]: got %b expected 0", t, pix_valid_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_shadow();
        test_wrap();
        test_modes();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
